// File: rtl/wb_arb_pkg.sv
// Shared types and default constants for the two-master Wishbone SDRAM arbiter.
package wb_arb_pkg;

  localparam int unsigned AW_DEF      = 32;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned SW_DEF      = 4;
  localparam int unsigned TIMEOUT_DEF = 64;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StGnt0,
    StGnt1,
    StErr
  } arb_state_e;

endpackage

// File: rtl/wb_arb_timeout.sv
// Wait-cycle counter: expires when a stalled strobe has waited TIMEOUT cycles.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // enable_i already excludes an ack, so an ack on the last count never expires.
  assign expire_o = enable_i && (count_q == LastCount);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter granting one of two Wishbone masters access to an SDRAM controller,
// with a per-transfer ack timeout that reports an error to the owning master.
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned SW      = SW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,

  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [SW-1:0] wb_sel_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,

  output logic [1:0]    grant_o
);

  arb_state_e state_q, state_d;
  // Last granted master; doubles as the owner while in StErr.
  logic       last_q, last_d;
  logic       to_clear, to_enable, to_expire;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = '0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    grant_o  = 2'b00;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;

    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? StGnt0 : StGnt1;
          last_d  = ~last_q;
        end else if (m0_cyc_i) begin
          state_d = StGnt0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = StGnt1;
          last_d  = 1'b1;
        end
      end
      StGnt0: begin
        wb_cyc_o = m0_cyc_i;
        wb_stb_o = m0_stb_i;
        wb_we_o  = m0_we_i;
        wb_sel_o = m0_sel_i;
        wb_adr_o = m0_adr_i;
        wb_dat_o = m0_dat_i;
        grant_o  = 2'b01;
        m0_ack_o = wb_ack_i;
        m0_err_o = to_expire;
        m0_dat_o = wb_dat_i;
        if (!m0_cyc_i) begin
          state_d = StIdle;
        end else if (to_expire) begin
          state_d = StErr;
        end
      end
      StGnt1: begin
        wb_cyc_o = m1_cyc_i;
        wb_stb_o = m1_stb_i;
        wb_we_o  = m1_we_i;
        wb_sel_o = m1_sel_i;
        wb_adr_o = m1_adr_i;
        wb_dat_o = m1_dat_i;
        grant_o  = 2'b10;
        m1_ack_o = wb_ack_i;
        m1_err_o = to_expire;
        m1_dat_o = wb_dat_i;
        if (!m1_cyc_i) begin
          state_d = StIdle;
        end else if (to_expire) begin
          state_d = StErr;
        end
      end
      StErr: begin
        if (last_q ? !m1_cyc_i : !m0_cyc_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign to_clear  = wb_ack_i || !wb_stb_o || (state_d != state_q);
  assign to_enable = wb_stb_o && !wb_ack_i;

  wb_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clear_i  (to_clear),
    .enable_i (to_enable),
    .expire_o (to_expire)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule
